// File: rtl/axif_frame_writer_pkg.sv
// Shared AXI constants and FSM encoding for the frame writer.
package axif_frame_writer_pkg;

  // AXI burst type for incrementing bursts
  localparam logic [1:0] BURST_INCR = 2'b01;

  // AXI write response code for a successful transfer
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Bufferable, modifiable normal memory
  localparam logic [3:0] AWCACHE_VAL = 4'b0011;

  // Unprivileged, secure, data access
  localparam logic [2:0] AWPROT_VAL = 3'b000;

  // No QoS hint
  localparam logic [3:0] AWQOS_VAL = 4'b0000;

  // Frame writer control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // AXI size encoding for a full-width beat of the given data width
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axif_frame_writer.sv
// Streams a frame of pixel words into memory as a sequence of AXI INCR write
// bursts, one burst outstanding at a time. Pixels arrive on a valid/ready
// stream that is wired straight onto the W channel while a burst is open.
module axif_frame_writer
  import axif_frame_writer_pkg::*;
#(
  parameter int N_PIXELS            = 16384,
  parameter int C_M_AXIF_ID_WIDTH   = 2,
  parameter int C_M_AXIF_DATA_WIDTH = 32,
  parameter int C_M_AXIF_ADDR_WIDTH = $clog2(N_PIXELS) + 2,
  parameter int BURST_LEN           = 16
) (
  input  logic                                M_AXI_ACLK,
  input  logic                                M_AXI_ARESET,

  input  logic                                i_start,
  input  logic [C_M_AXIF_ADDR_WIDTH-1:0]      i_base_addr,
  input  logic [$clog2(N_PIXELS):0]           i_n_pixels,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_err,

  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [C_M_AXIF_DATA_WIDTH-1:0]      s_data,

  output logic [C_M_AXIF_ID_WIDTH-1:0]        M_AXI_AWID,
  output logic [C_M_AXIF_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic [7:0]                          M_AXI_AWLEN,
  output logic [2:0]                          M_AXI_AWSIZE,
  output logic [1:0]                          M_AXI_AWBURST,
  output logic                                M_AXI_AWLOCK,
  output logic [3:0]                          M_AXI_AWCACHE,
  output logic [2:0]                          M_AXI_AWPROT,
  output logic [3:0]                          M_AXI_AWQOS,
  output logic                                M_AXI_AWVALID,
  input  logic                                M_AXI_AWREADY,

  output logic [C_M_AXIF_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [C_M_AXIF_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                                M_AXI_WLAST,
  output logic                                M_AXI_WVALID,
  input  logic                                M_AXI_WREADY,

  input  logic [C_M_AXIF_ID_WIDTH-1:0]        M_AXI_BID,
  input  logic [1:0]                          M_AXI_BRESP,
  input  logic                                M_AXI_BVALID,
  output logic                                M_AXI_BREADY
);

  localparam int AW = C_M_AXIF_ADDR_WIDTH;
  localparam int CW = $clog2(N_PIXELS) + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [7:0]      awlen_q, awlen_d;
  logic [7:0]      beat_q, beat_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            awvalid_q, awvalid_d;
  logic            bready_q, bready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            in_data;
  logic            w_fire;
  logic            last_beat;
  logic [AW-1:0]   start_addr;
  logic [AW-1:0]   next_addr;

  // The response ID is not needed with a single outstanding burst, and the
  // base address is always word aligned internally.
  logic            unused_inputs;
  assign unused_inputs = ^{M_AXI_BID, i_base_addr[1:0]};

  // AWLEN for the next burst: the full burst, or whatever pixels are left
  function automatic logic [7:0] burst_awlen(input logic [CW-1:0] rem);
    if (32'(rem) >= BURST_LEN) return 8'(BURST_LEN - 1);
    return 8'(rem - CW'(1));
  endfunction

  assign start_addr = {i_base_addr[AW-1:2], 2'b00};
  // Wraps naturally at the address width
  assign next_addr  = awaddr_q + AW'((32'(awlen_q) + 32'd1) << 2);

  // W channel is a direct pass-through of the pixel stream while a burst is open
  assign in_data      = (state_q == ST_DATA);
  assign M_AXI_WVALID = in_data & s_valid;
  assign s_ready      = in_data & M_AXI_WREADY;
  assign M_AXI_WDATA  = s_data;
  assign M_AXI_WSTRB  = '1;
  assign last_beat    = (beat_q == awlen_q);
  assign M_AXI_WLAST  = in_data & last_beat;
  assign w_fire       = M_AXI_WVALID & M_AXI_WREADY;

  // Fixed write-address attributes
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWSIZE  = axi_size(C_M_AXIF_DATA_WIDTH);
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = AWCACHE_VAL;
  assign M_AXI_AWPROT  = AWPROT_VAL;
  assign M_AXI_AWQOS   = AWQOS_VAL;

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = awlen_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

  // Next-state and next-output computation for the burst sequencer
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    beat_d    = beat_q;
    rem_d     = rem_q;
    awvalid_d = awvalid_q;
    bready_d  = bready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_n_pixels == '0) begin
            // Empty frame completes at once and leaves the error flag alone
            done_d = 1'b1;
          end else begin
            state_d   = ST_ADDR;
            awaddr_d  = start_addr;
            rem_d     = i_n_pixels;
            awlen_d   = burst_awlen(i_n_pixels);
            awvalid_d = 1'b1;
            busy_d    = 1'b1;
            err_d     = 1'b0;
          end
        end
      end

      ST_ADDR: begin
        if (M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          beat_d    = '0;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_fire) begin
          beat_d = beat_q + 8'd1;
          rem_d  = rem_q - CW'(1);
          if (last_beat) begin
            state_d  = ST_RESP;
            bready_d = 1'b1;
          end
        end
      end

      ST_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          // Errors are recorded but the frame carries on to completion
          if (M_AXI_BRESP != RESP_OKAY) err_d = 1'b1;
          awaddr_d = next_addr;
          if (rem_q == '0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_ADDR;
            awvalid_d = 1'b1;
            awlen_d   = burst_awlen(rem_q);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any burst in flight
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= ST_IDLE;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      beat_q    <= '0;
      rem_q     <= '0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      beat_q    <= beat_d;
      rem_q     <= rem_d;
      awvalid_q <= awvalid_d;
      bready_q  <= bready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Address channel must hold steady until the slave accepts it
  property p_aw_stable;
    @(posedge M_AXI_ACLK) disable iff (M_AXI_ARESET)
      (M_AXI_AWVALID && !M_AXI_AWREADY) |=>
        (M_AXI_AWVALID && $stable(M_AXI_AWADDR) && $stable(M_AXI_AWLEN));
  endproperty
  a_aw_stable: assert property (p_aw_stable);

endmodule

// File: tb/tb_axif_frame_writer.sv
// Self-checking bench for axif_frame_writer: a reference model pushes the
// expected AW and W traffic for each frame into queues, and a cycle-driven
// slave model pops and compares as the DUT produces handshakes.
module tb_axif_frame_writer;

  localparam int N_PIXELS = 16384;
  localparam int IDW      = 2;
  localparam int DW       = 32;
  localparam int AW       = $clog2(N_PIXELS) + 2;
  localparam int CW       = $clog2(N_PIXELS) + 1;
  localparam int BL       = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_start;
  logic [AW-1:0]   i_base_addr;
  logic [CW-1:0]   i_n_pixels;
  logic            o_busy, o_done, o_err;
  logic            s_valid, s_ready;
  logic [DW-1:0]   s_data;
  logic [IDW-1:0]  awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;

  axif_frame_writer #(
    .N_PIXELS(N_PIXELS), .C_M_AXIF_ID_WIDTH(IDW), .C_M_AXIF_DATA_WIDTH(DW),
    .C_M_AXIF_ADDR_WIDTH(AW), .BURST_LEN(BL)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .i_start(i_start), .i_base_addr(i_base_addr), .i_n_pixels(i_n_pixels),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
    .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock),
    .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } w_exp_t;

  aw_exp_t       aw_q[$];
  w_exp_t        w_q[$];
  logic [DW-1:0] pix [0:63];
  int            checks = 0;
  int            errors = 0;

  task automatic drive_idle();
    i_start = 1'b0; s_valid = 1'b0; s_data = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
  endtask

  task automatic test_reset();
    i_base_addr = '0; i_n_pixels = '0;
    drive_idle();
    #1;
    checks++;
    if ({awvalid, wvalid, wlast, bready, s_ready, o_busy, o_done, o_err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {awvalid, wvalid, wlast, bready, s_ready, o_busy, o_done, o_err});
    end
    checks++;
    if (awaddr !== '0 || awlen !== 8'd0) begin
      errors++;
      $display("FAIL reset_aw got addr=%h len=%0d want 0/0", awaddr, awlen);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one frame through the slave model; err_burst < 0 means no error
  // response, abort_beat >= 0 asserts reset once that many beats have gone.
  task automatic run_frame(input int base, input int n, input int aw_delay,
                           input bit gapped, input int err_burst,
                           input bit poke_start, input int abort_beat,
                           input bit exp_err_in);
    logic [AW-1:0] a;
    logic [AW-1:0] prev_addr;
    logic [7:0]    prev_len;
    aw_exp_t       ea;
    w_exp_t        ew;
    int rem, len, k, nbursts, cyc, pix_idx, beats, bursts_b, aw_wait;
    bit aw_open, b_pend, last_b_prev, last_b_now, fin, prev_awv, first, exp_err;

    for (int i = 0; i < 64; i++) pix[i] = $urandom;
    // Reference model of the burst split
    a = AW'(base) & ~AW'(3); rem = n; k = 0; nbursts = 0;
    while (rem > 0) begin
      len = (rem >= BL) ? BL : rem;
      aw_q.push_back('{addr: a, len: 8'(len - 1)});
      for (int j = 0; j < len; j++) begin
        w_q.push_back('{data: pix[k], last: (j == len - 1)});
        k++;
      end
      a = a + AW'(len * 4);
      rem -= len;
      nbursts++;
    end
    exp_err = (err_burst >= 0 && err_burst < nbursts);

    @(negedge clk);
    drive_idle();
    i_start = 1'b1; i_base_addr = AW'(base); i_n_pixels = CW'(n);
    @(posedge clk);
    #1 i_start = 1'b0;

    cyc = 0; pix_idx = 0; beats = 0; bursts_b = 0; aw_wait = 0;
    aw_open = 0; b_pend = 0; last_b_prev = 0; fin = 0; prev_awv = 0; first = 1;
    prev_addr = '0; prev_len = '0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0;
      if (poke_start && cyc == 3) begin
        i_start = 1'b1; i_base_addr = AW'(32'h3000); i_n_pixels = CW'(5);
      end
      if (awvalid) begin
        awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else awready = 1'b0;
      wready  = gapped ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_valid = (pix_idx < n) && (gapped ? ($urandom_range(0, 2) != 0) : 1'b1);
      s_data  = (pix_idx < 64) ? pix[pix_idx] : '0;
      bvalid  = b_pend;
      bresp   = (bursts_b == err_burst) ? 2'b10 : 2'b00;

      if (abort_beat >= 0 && beats == abort_beat) begin
        s_valid = 1'b1; wready = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({awvalid, wvalid, wlast, bready, s_ready, o_busy} !== 6'b0) begin
          errors++;
          $display("FAIL abort_async got %b want 000000",
                   {awvalid, wvalid, wlast, bready, s_ready, o_busy});
        end
        aw_q.delete(); w_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          awready = 1'b1; wready = 1'b1; s_valid = 1'b1;
          #1;
          checks++;
          if ({awvalid, wvalid, o_busy, o_done} !== 4'b0) begin
            errors++;
            $display("FAIL abort_resume cycle %0d got %b want 0000", c,
                     {awvalid, wvalid, o_busy, o_done});
          end
        end
        drive_idle();
        return;
      end

      #1;
      last_b_now = 0;
      if (first) begin
        checks++;
        if (o_busy !== 1'b1 || o_err !== 1'b0) begin
          errors++;
          $display("FAIL start_flags got busy=%b err=%b want busy=1 err=0", o_busy, o_err);
        end
        first = 0;
      end
      if (awvalid) begin
        if (aw_open) begin
          errors++;
          $display("FAIL outstanding got AWVALID with burst open want none");
        end
        if (prev_awv) begin
          checks++;
          if (awaddr !== prev_addr || awlen !== prev_len) begin
            errors++;
            $display("FAIL aw_stable got %h/%0d want %h/%0d", awaddr, awlen, prev_addr, prev_len);
          end
        end
        prev_awv = 1; prev_addr = awaddr; prev_len = awlen;
        if (awready) begin
          checks++;
          if (aw_q.size() == 0) begin
            errors++;
            $display("FAIL aw_extra got addr=%h len=%0d want no AW", awaddr, awlen);
          end else begin
            ea = aw_q.pop_front();
            if (awaddr !== ea.addr || awlen !== ea.len) begin
              errors++;
              $display("FAIL aw_fields got addr=%h len=%0d want addr=%h len=%0d",
                       awaddr, awlen, ea.addr, ea.len);
            end
          end
          checks++;
          if ({awid, awsize, awburst, awlock, awcache, awprot, awqos} !==
              {2'b00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000}) begin
            errors++;
            $display("FAIL aw_const got %h want %h",
                     {awid, awsize, awburst, awlock, awcache, awprot, awqos},
                     {2'b00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
          end
          aw_open = 1; prev_awv = 0; aw_wait = 0;
        end
      end else prev_awv = 0;

      if (wvalid && wready) begin
        checks++;
        if (w_q.size() == 0) begin
          errors++;
          $display("FAIL w_extra got data=%h want no beat", wdata);
        end else begin
          ew = w_q.pop_front();
          if (wdata !== ew.data || wlast !== ew.last || wstrb !== 4'hF || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL w_beat %0d got data=%h last=%b strb=%h rdy=%b want data=%h last=%b strb=f rdy=1",
                     beats, wdata, wlast, wstrb, s_ready, ew.data, ew.last);
          end
        end
        pix_idx++; beats++;
        if (wlast) b_pend = 1;
      end

      if (bvalid && bready) begin
        b_pend = 0; aw_open = 0; bursts_b++;
        if (bursts_b == nbursts) last_b_now = 1;
      end

      if (o_done) begin
        checks++;
        if (!last_b_prev || o_busy !== 1'b0 || o_err !== exp_err) begin
          errors++;
          $display("FAIL done_pulse got afterB=%b busy=%b err=%b want 1/0/%b",
                   last_b_prev, o_busy, o_err, exp_err);
        end
        fin = 1;
      end
      last_b_prev = last_b_now;
    end

    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL frame_timeout got no o_done want o_done within 3000 cycles");
    end
    checks++;
    if (aw_q.size() != 0 || w_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got aw=%0d w=%0d want 0/0", aw_q.size(), w_q.size());
    end
    aw_q.delete(); w_q.delete();
    drive_idle();
    @(negedge clk);
    #1;
    checks++;
    if (o_done !== 1'b0 || awvalid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_frame got done=%b awv=%b busy=%b want 0/0/0", o_done, awvalid, o_busy);
    end
    if (exp_err_in) begin
      checks++;
      if (o_err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky got %b want 1", o_err);
      end
    end
  endtask

  task automatic test_zero_length(input logic exp_err);
    @(negedge clk);
    drive_idle();
    i_start = 1'b1; i_base_addr = AW'(32'h80); i_n_pixels = '0;
    @(negedge clk);
    i_start = 1'b0;
    #1;
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_err !== exp_err) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b err=%b want 1/0/%b", o_done, o_busy, o_err, exp_err);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({awvalid, o_busy, o_done} !== 3'b0) begin
        errors++;
        $display("FAIL zero_quiet cycle %0d got %b want 000", c, {awvalid, o_busy, o_done});
      end
    end
  endtask

  task automatic test_single_burst();     run_frame(32'h0,    16, 0, 0, -1, 0, -1, 0); endtask
  task automatic test_multi_burst();      run_frame(32'h100,  40, 0, 0, -1, 0, -1, 0); endtask
  task automatic test_backpressure();     run_frame(32'h206,  37, 5, 1, -1, 1, -1, 0); endtask
  task automatic test_bresp_error();      run_frame(32'h400,  48, 0, 1,  1, 0, -1, 1); endtask
  task automatic test_err_clear_wrap();   run_frame(32'hFFC0, 20, 2, 0, -1, 0, -1, 0); endtask
  task automatic test_reset_mid_data();   run_frame(32'h0,    32, 0, 0, -1, 0,  7, 0); endtask
  task automatic test_back_to_back();
    run_frame(32'h40, 5, 1, 1, -1, 0, -1, 0);
    run_frame(32'h60, 17, 0, 1, 0, 0, -1, 1);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_backpressure();
    test_bresp_error();
    test_zero_length(1'b1);
    test_err_clear_wrap();
    test_zero_length(1'b0);
    test_reset_mid_data();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
